// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data_mem.
// Port A (CPU) has priority; port B (debug) gets a forced grant after
// MAX_WAIT consecutive denials. Ports:
//   clk, reset          : clock, synchronous active-high reset
//   a_* / b_*           : req/we/addr/wdata in, gnt/rvalid/rdata out
//   mem_write/addr/wdata: to data_mem; mem_rdata from data_mem
module data_mem_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 5,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [RAM_ADDR_BITS-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0]     a_wdata,
  output logic                     a_gnt,
  output logic                     a_rvalid,
  output logic [RAM_WIDTH-1:0]     a_rdata,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [RAM_ADDR_BITS-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0]     b_wdata,
  output logic                     b_gnt,
  output logic                     b_rvalid,
  output logic [RAM_WIDTH-1:0]     b_rdata,
  output logic                     mem_write,
  output logic [RAM_ADDR_BITS-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]     mem_wdata,
  input  logic [RAM_WIDTH-1:0]     mem_rdata
);

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t               state_q, state_d;
  logic [3:0]           wait_q, wait_d;
  logic                 a_rv_q, a_rv_d;
  logic                 b_rv_q, b_rv_d;
  logic [RAM_WIDTH-1:0] a_hold_q, b_hold_q;

  always_comb begin
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      NORMAL: begin
        if (a_req) begin
          a_gnt = 1'b1;
        end else if (b_req) begin
          b_gnt = 1'b1;
        end
        if (b_req && !b_gnt) begin
          // Counter holds at its last value; the forced grant clears it.
          if (wait_q >= WAIT_LAST) begin
            state_d = FORCE_B;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end else begin
          wait_d = 4'd0;
        end
      end
      FORCE_B: begin
        // A dropped b_req here just returns to NORMAL ungranted.
        b_gnt   = b_req;
        state_d = NORMAL;
        wait_d  = 4'd0;
      end
      default: begin
        state_d = NORMAL;
        wait_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      a_gnt: begin
        mem_write = a_we;
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
      end
      b_gnt: begin
        mem_write = b_we;
        mem_addr  = b_addr;
        mem_wdata = b_wdata;
      end
      default: ;
    endcase
  end

  // One flag per port doubles as the read-owner tag.
  assign a_rv_d = a_gnt & ~a_we;
  assign b_rv_d = b_gnt & ~b_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= NORMAL;
      wait_q   <= 4'd0;
      a_rv_q   <= 1'b0;
      b_rv_q   <= 1'b0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
      if (a_rv_q) a_hold_q <= mem_rdata;
      if (b_rv_q) b_hold_q <= mem_rdata;
    end
  end

  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign a_rdata  = a_rv_q ? mem_rdata : a_hold_q;
  assign b_rdata  = b_rv_q ? mem_rdata : b_hold_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a behavioural data_mem and
// per-port read-data scoreboards.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_write;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [32];
  logic [31:0] shadow [32];
  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] la, lb;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .RAM_WIDTH(32),
    .RAM_ADDR_BITS(5),
    .MAX_WAIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("excl", 32'(a_gnt & b_gnt), 32'd0);
    chk("mwr", 32'(mem_write),
        32'((a_gnt & a_we) | (b_gnt & b_we)));
    if (!a_gnt && !b_gnt) begin
      chk("idle_addr", 32'(mem_addr), 32'd0);
      chk("idle_wd", mem_wdata, 32'd0);
    end
    if (reset) begin
      qa.delete();
      qb.delete();
      la = '0;
      lb = '0;
    end else begin
      if (a_rvalid) begin
        if (qa.size() == 0) chk("a_spur", 32'd1, 32'd0);
        else chk("a_rdata", a_rdata, qa.pop_front());
        la = a_rdata;
      end else begin
        chk("a_hold", a_rdata, la);
      end
      if (b_rvalid) begin
        if (qb.size() == 0) chk("b_spur", 32'd1, 32'd0);
        else chk("b_rdata", b_rdata, qb.pop_front());
        lb = b_rdata;
      end else begin
        chk("b_hold", b_rdata, lb);
      end
      if (a_gnt && !a_we) qa.push_back(shadow[a_addr]);
      if (b_gnt && !b_we) qb.push_back(shadow[b_addr]);
    end
    if (a_gnt && a_we) shadow[a_addr] = a_wdata;
    if (b_gnt && b_we) shadow[b_addr] = b_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic acc(input bit pb, input logic we,
                     input logic [4:0] addr, input logic [31:0] d);
    int n;
    n = 0;
    if (pb) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
    end
    forever begin
      @(negedge clk);
      if (pb ? b_gnt : a_gnt) break;
      n++;
      if (n > 20) begin
        chk("gnt_timeout", 32'd0, 32'd1);
        break;
      end
      step();
    end
    step();
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    la = '0; lb = '0;
    a_we = 0; a_addr = 0; a_wdata = 0;
    b_we = 0; b_addr = 0; b_wdata = 0;
    #1;
    do_reset();
    @(negedge clk);
    chk("rst_arv", 32'(a_rvalid), 32'd0);
    chk("rst_brv", 32'(b_rvalid), 32'd0);
    chk("rst_ard", a_rdata, 32'd0);
    chk("rst_brd", b_rdata, 32'd0);
    step();

    acc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    acc(1'b0, 1'b0, 5'd5, 32'h0);
    step(); step();
    @(negedge clk);
    chk("a_held", a_rdata, 32'hDEADBEEF);
    step();

    acc(1'b1, 1'b1, 5'd31, 32'h12345678);
    acc(1'b1, 1'b0, 5'd31, 32'h0);
    step(); step();
    @(negedge clk);
    chk("b_held", b_rdata, 32'h12345678);
    step();

    acc(1'b0, 1'b1, 5'd1, 32'h11);
    acc(1'b1, 1'b1, 5'd2, 32'h22);
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd1;
    @(negedge clk);
    chk("il_agnt", 32'(a_gnt), 32'd1);
    step();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd2;
    @(negedge clk);
    chk("il_bgnt", 32'(b_gnt), 32'd1);
    chk("il_arv", 32'(a_rvalid), 32'd1);
    chk("il_ard", a_rdata, 32'h11);
    chk("il_brv0", 32'(b_rvalid), 32'd0);
    step();
    b_req = 1'b0;
    @(negedge clk);
    chk("il_brv", 32'(b_rvalid), 32'd1);
    chk("il_brd", b_rdata, 32'h22);
    chk("il_arv0", 32'(a_rvalid), 32'd0);
    step();

    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd31;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("cont_a", 32'(a_gnt), 32'(i % 5 != 4));
      chk("cont_b", 32'(b_gnt), 32'(i % 5 == 4));
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    step(); step();

    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sv_wait", 32'(b_gnt), 32'd0);
      step();
    end
    b_req = 1'b0;
    @(negedge clk);
    chk("sv_drop", 32'(b_gnt), 32'd0);
    step();
    b_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("sv_regnt", 32'(b_gnt), 32'(i == 4));
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    step(); step();

    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd3;
    @(negedge clk);
    chk("mr_gnt", 32'(a_gnt), 32'd1);
    step();
    a_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_arv", 32'(a_rvalid), 32'd0);
    chk("mr_ard", a_rdata, 32'd0);
    step();

    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
    step();
    reset = 1'b0;
    a_req = 1'b0;
    @(negedge clk);
    chk("rg_arv", 32'(a_rvalid), 32'd0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
